replication_sequencer: RTL

REPLICATION_SEQUENCER -- requirements
Module: replication_sequencer

---
 rtl/replication_sequencer_if.sv | 29 ++
 rtl/replication_sequencer.sv | 92 +++++++++
 2 files changed

// File: rtl/replication_sequencer_if.sv
// Request/beat bundle for replication_sequencer: the operand request channel,
// the byte-beat output channel and the status outputs.
// Modports: master = request source / beat sink, slave = the sequencer.
interface replication_sequencer_if;
    // Request channel
    logic       in_valid;
    logic       in_ready;
    logic [2:0] in_a;
    logic [2:0] in_b;
    logic       in_mode;
    // Beat channel
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_last;
    // Status
    logic       busy;
    logic [7:0] frame_cnt;

    modport master (
        output in_valid, in_a, in_b, in_mode, out_ready,
        input  in_ready, out_valid, out_data, out_last, busy, frame_cnt
    );

    modport slave (
        input  in_valid, in_a, in_b, in_mode, out_ready,
        output in_ready, out_valid, out_data, out_last, busy, frame_cnt
    );
endinterface

// File: rtl/replication_sequencer.sv
// Builds a frame from operands A/B by replication and emits it LSB-byte first.
// Latency: first beat valid the cycle after capture; one beat per accepted cycle.
// Backpressure: beats advance only on out_valid && out_ready; data/last hold while stalled.
// Ports: clk, rst_n (async active-low), bus (slave modport: in_* request,
//        out_* beat stream, busy, frame_cnt).
module replication_sequencer #(
    parameter int REP_N = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    replication_sequencer_if.slave bus
);

    typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

    state_t      state_q;
    logic        mode_q;
    logic [31:0] frame_q;
    logic [1:0]  beat_q;
    logic [1:0]  beat_d;
    logic        out_valid_q;
    logic [7:0]  out_data_q;
    logic        out_last_q;
    logic [7:0]  frame_cnt_q;
    logic [31:0] cap_frame;

    // Frame image for the request currently on the input bus.
    always_comb begin
        cap_frame = '0;
        if (bus.in_mode) begin
            cap_frame[11:0] = {bus.in_a, bus.in_b, bus.in_a, bus.in_b};
        end else begin
            cap_frame[3*REP_N-1:0] = {REP_N{bus.in_a}};
        end
    end

    assign beat_d = beat_q + 2'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            mode_q      <= 1'b0;
            frame_q     <= '0;
            beat_q      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        state_q     <= SEND;
                        mode_q      <= bus.in_mode;
                        frame_q     <= cap_frame;
                        beat_q      <= '0;
                        out_valid_q <= 1'b1;
                        out_data_q  <= cap_frame[7:0];
                        // Every frame has at least two beats, so beat 0 is never last.
                        out_last_q  <= 1'b0;
                    end
                end
                SEND: begin
                    if (bus.out_ready) begin
                        if (out_last_q) begin
                            state_q     <= IDLE;
                            beat_q      <= '0;
                            out_valid_q <= 1'b0;
                            out_data_q  <= '0;
                            out_last_q  <= 1'b0;
                            frame_cnt_q <= frame_cnt_q + 8'd1;
                        end else begin
                            beat_q     <= beat_d;
                            out_data_q <= frame_q[{beat_d, 3'b000} +: 8];
                            // Mode 0 ends on beat 1, mode 1 on beat 3.
                            out_last_q <= mode_q ? (beat_d == 2'd3) : (beat_d == 2'd1);
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.busy      = (state_q == SEND);
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_last  = out_last_q;
    assign bus.frame_cnt = frame_cnt_q;

endmodule
